hw_ctrl_seq: RTL and testbench

HW_CTRL_SEQ -- requirements
Module: hw_ctrl_seq

---
 rtl/hw_ctrl_seq_if.sv | 47 ++++
 rtl/hw_ctrl_seq.sv | 195 +++++++++++++++++++
 tb/tb_hw_ctrl_seq.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/hw_ctrl_seq_if.sv
// -----------------------------------------------------------------------------
// hw_ctrl_seq_if
// Bundles the console, decoder and beat-output signals of hw_ctrl_seq.
//   master : the side that drives console/decoder requests (qd, sw, short_i,
//            long_i, stop_i, sst0_i[, int_req]) and observes the beat outputs.
//   slave  : the sequencer itself (drives w, beat_idx, st0, running
//            [, int_ack, int_cyc]).
// Optional feature macro: HW_CTRL_SEQ_INT_EN adds int_req/int_ack/int_cyc.
// -----------------------------------------------------------------------------
interface hw_ctrl_seq_if #(
    parameter int MAX_BEATS = 3,
    parameter int BI_W      = $clog2(MAX_BEATS)
);
    logic                 qd;
    logic [2:0]           sw;
    logic                 short_i;
    logic                 long_i;
    logic                 stop_i;
    logic                 sst0_i;
    logic [MAX_BEATS-1:0] w;
    logic [BI_W-1:0]      beat_idx;
    logic                 st0;
    logic                 running;
`ifdef HW_CTRL_SEQ_INT_EN
    logic                 int_req;
    logic                 int_ack;
    logic                 int_cyc;

    modport master (
        output qd, sw, short_i, long_i, stop_i, sst0_i, int_req,
        input  w, beat_idx, st0, running, int_ack, int_cyc
    );
    modport slave (
        input  qd, sw, short_i, long_i, stop_i, sst0_i, int_req,
        output w, beat_idx, st0, running, int_ack, int_cyc
    );
`else
    modport master (
        output qd, sw, short_i, long_i, stop_i, sst0_i,
        input  w, beat_idx, st0, running
    );
    modport slave (
        input  qd, sw, short_i, long_i, stop_i, sst0_i,
        output w, beat_idx, st0, running
    );
`endif
endinterface

// File: rtl/hw_ctrl_seq.sv
// -----------------------------------------------------------------------------
// hw_ctrl_seq
// Beat (W1..Wn) generator for a microprogrammed console/CPU controller.
// A rising edge on qd starts the sequencer from the saved resume beat; decoder
// requests shorten/extend/stop the instruction; st0 tracks console/program
// phase. A change of console mode (sw) aborts everything back to HALT at W1.
// Ports:
//   t3   : clock, all state changes on its rising edge
//   clr  : synchronous active-high reset (sampled on t3)
//   bus  : hw_ctrl_seq_if.slave (qd, sw, decoder requests in; w, beat_idx,
//          st0, running [, int_ack, int_cyc] out)
// Optional feature macro: HW_CTRL_SEQ_INT_EN enables the two-beat INT cycle.
// -----------------------------------------------------------------------------
module hw_ctrl_seq #(
    parameter int MAX_BEATS = 3,
    parameter int BI_W      = $clog2(MAX_BEATS)
) (
    input  logic          t3,
    input  logic          clr,
    hw_ctrl_seq_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_HALT = 2'b00,
        ST_RUN  = 2'b01,
        ST_INT  = 2'b10
    } state_e;

    state_e               state_q, state_d;
    logic [BI_W-1:0]      beat_q, beat_d;
    logic [BI_W-1:0]      resume_q, resume_d;
    logic                 st0_q, st0_d;
    logic                 qd_q, qd_d;
    logic [2:0]           sw_q, sw_d;
    logic [MAX_BEATS-1:0] w_q, w_d;
    logic                 running_q, running_d;

    logic                 qd_rise_s;
    logic                 mode_chg_s;
    logic                 last_s;
    logic                 stop_now_s;
    logic [BI_W-1:0]      next_beat_s;

`ifdef HW_CTRL_SEQ_INT_EN
    logic                 int_ack_q, int_ack_d;
    logic                 int_cyc_q, int_cyc_d;
    // A stop seen during INT is held here until the sequencer is back in RUN.
    logic                 stop_pend_q, stop_pend_d;
`endif

    // Edge/mode detection and the end-of-instruction decision for the current beat.
    always_comb begin
        qd_rise_s   = bus.qd & ~qd_q;
        mode_chg_s  = (bus.sw != sw_q);
        last_s      = bus.short_i
                    | (~bus.long_i & (beat_q >= BI_W'(1)))
                    | (beat_q == BI_W'(MAX_BEATS - 1));
        next_beat_s = last_s ? {BI_W{1'b0}} : (beat_q + BI_W'(1));
`ifdef HW_CTRL_SEQ_INT_EN
        stop_now_s  = bus.stop_i | stop_pend_q;
`else
        stop_now_s  = bus.stop_i;
`endif
    end

    // Next-state, st0 and registered-output computation.
    always_comb begin
        state_d  = state_q;
        beat_d   = beat_q;
        resume_d = resume_q;
        st0_d    = st0_q;
        qd_d     = bus.qd;
        sw_d     = bus.sw;
`ifdef HW_CTRL_SEQ_INT_EN
        int_ack_d   = 1'b0;
        stop_pend_d = stop_pend_q;
`endif
        if (mode_chg_s) begin
            // Console mode change wins over every other request.
            state_d  = ST_HALT;
            beat_d   = {BI_W{1'b0}};
            resume_d = {BI_W{1'b0}};
            st0_d    = 1'b0;
`ifdef HW_CTRL_SEQ_INT_EN
            stop_pend_d = 1'b0;
`endif
        end else begin
            // st0 clear uses the beat currently on w (W2) and the live mode.
            if (bus.sst0_i) begin
                st0_d = 1'b1;
            end else if (st0_q & w_q[1] & (bus.sw == 3'b100)) begin
                st0_d = 1'b0;
            end else begin
                st0_d = st0_q;
            end

            case (state_q)
                ST_HALT: begin
                    if (qd_rise_s) begin
                        state_d = ST_RUN;
                        beat_d  = resume_q;
                    end else begin
                        state_d = ST_HALT;
                    end
                end
                ST_RUN: begin
                    if (stop_now_s) begin
                        state_d  = ST_HALT;
                        resume_d = next_beat_s;
                        beat_d   = next_beat_s;
`ifdef HW_CTRL_SEQ_INT_EN
                        stop_pend_d = 1'b0;
                    end else if (last_s & st0_q & bus.int_req) begin
                        state_d   = ST_INT;
                        beat_d    = {BI_W{1'b0}};
                        int_ack_d = 1'b1;
`endif
                    end else begin
                        beat_d = next_beat_s;
                    end
                end
`ifdef HW_CTRL_SEQ_INT_EN
                ST_INT: begin
                    stop_pend_d = stop_pend_q | bus.stop_i;
                    // INT is always exactly W1, W2, then back to RUN at W1.
                    if (beat_q == {BI_W{1'b0}}) begin
                        beat_d = BI_W'(1);
                    end else begin
                        state_d = ST_RUN;
                        beat_d  = {BI_W{1'b0}};
                    end
                end
`endif
                default: begin
                    state_d = ST_HALT;
                    beat_d  = {BI_W{1'b0}};
                end
            endcase
        end

        // Outputs are registered from the next state so w lags its cause by one edge.
        running_d = (state_d != ST_HALT);
        if (running_d) begin
            w_d = MAX_BEATS'(1'b1) << beat_d;
        end else begin
            w_d = {MAX_BEATS{1'b0}};
        end
`ifdef HW_CTRL_SEQ_INT_EN
        int_cyc_d = (state_d == ST_INT);
`endif
    end

    // State and output registers with synchronous clear.
    always_ff @(posedge t3) begin
        if (clr) begin
            state_q   <= ST_HALT;
            beat_q    <= {BI_W{1'b0}};
            resume_q  <= {BI_W{1'b0}};
            st0_q     <= 1'b0;
            qd_q      <= bus.qd;
            sw_q      <= bus.sw;
            w_q       <= {MAX_BEATS{1'b0}};
            running_q <= 1'b0;
`ifdef HW_CTRL_SEQ_INT_EN
            int_ack_q   <= 1'b0;
            int_cyc_q   <= 1'b0;
            stop_pend_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            beat_q    <= beat_d;
            resume_q  <= resume_d;
            st0_q     <= st0_d;
            qd_q      <= qd_d;
            sw_q      <= sw_d;
            w_q       <= w_d;
            running_q <= running_d;
`ifdef HW_CTRL_SEQ_INT_EN
            int_ack_q   <= int_ack_d;
            int_cyc_q   <= int_cyc_d;
            stop_pend_q <= stop_pend_d;
`endif
        end
    end

    assign bus.w        = w_q;
    assign bus.beat_idx = beat_q;
    assign bus.st0      = st0_q;
    assign bus.running  = running_q;
`ifdef HW_CTRL_SEQ_INT_EN
    assign bus.int_ack  = int_ack_q;
    assign bus.int_cyc  = int_cyc_q;
`endif

endmodule

// File: tb/tb_hw_ctrl_seq.sv
// Self-checking bench for hw_ctrl_seq: two instances (MAX_BEATS=3 and 4) share
// stimulus; a behavioural model predicts outputs, checked every falling edge.
module tb_hw_ctrl_seq;

    logic       t3 = 1'b0;
    logic       clr, qd, short_i, long_i, stop_i, sst0_i;
    logic [2:0] sw;
`ifdef HW_CTRL_SEQ_INT_EN
    logic       int_req;
`endif

    always #5 t3 = ~t3;

    hw_ctrl_seq_if #(.MAX_BEATS(3)) if3 ();
    hw_ctrl_seq_if #(.MAX_BEATS(4)) if4 ();

    assign if3.qd = qd;       assign if4.qd = qd;
    assign if3.sw = sw;       assign if4.sw = sw;
    assign if3.short_i = short_i;  assign if4.short_i = short_i;
    assign if3.long_i  = long_i;   assign if4.long_i  = long_i;
    assign if3.stop_i  = stop_i;   assign if4.stop_i  = stop_i;
    assign if3.sst0_i  = sst0_i;   assign if4.sst0_i  = sst0_i;
`ifdef HW_CTRL_SEQ_INT_EN
    assign if3.int_req = int_req;  assign if4.int_req = int_req;
`endif

    hw_ctrl_seq #(.MAX_BEATS(3)) dut3 (.t3(t3), .clr(clr), .bus(if3.slave));
    hw_ctrl_seq #(.MAX_BEATS(4)) dut4 (.t3(t3), .clr(clr), .bus(if4.slave));

    int n_cmp = 0;
    int n_mis = 0;
    bit chk_en = 1'b0;

    // Model: phase 0=halted, 1=running, 2=interrupt cycle; k = beat number (0 = W1).
    int         mb[2] = '{3, 4};
    int         m_phase[2], m_k[2], m_res[2];
    bit         m_st0[2], m_qdp[2], m_ack[2], m_pend[2];
    logic [2:0] m_swp[2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step(input int i);
        bit qr, wmc, onw2, last, stp;
        int nk;
        qr = qd && !m_qdp[i];
        m_ack[i] = 1'b0;
        if (clr) begin
            m_phase[i] = 0; m_k[i] = 0; m_res[i] = 0; m_st0[i] = 1'b0; m_pend[i] = 1'b0;
        end else begin
            wmc  = (sw != m_swp[i]);
            onw2 = (m_phase[i] != 0) && (m_k[i] == 1);
            if (wmc) begin
                m_phase[i] = 0; m_k[i] = 0; m_res[i] = 0; m_st0[i] = 1'b0; m_pend[i] = 1'b0;
            end else begin
                if (m_phase[i] == 0) begin
                    if (qr) begin m_phase[i] = 1; m_k[i] = m_res[i]; end
                end else if (m_phase[i] == 1) begin
                    last = short_i || (!long_i && m_k[i] >= 1) || (m_k[i] == mb[i] - 1);
                    nk   = last ? 0 : m_k[i] + 1;
                    stp  = stop_i || m_pend[i];
                    m_pend[i] = 1'b0;
                    if (stp) begin
                        m_phase[i] = 0; m_res[i] = nk;
`ifdef HW_CTRL_SEQ_INT_EN
                    end else if (last && m_st0[i] && int_req) begin
                        m_phase[i] = 2; m_k[i] = 0; m_ack[i] = 1'b1;
`endif
                    end else begin
                        m_k[i] = nk;
                    end
                end else begin
                    m_pend[i] = m_pend[i] || stop_i;
                    if (m_k[i] == 0) m_k[i] = 1;
                    else begin m_phase[i] = 1; m_k[i] = 0; end
                end
                if (sst0_i) m_st0[i] = 1'b1;
                else if (m_st0[i] && onw2 && sw == 3'b100) m_st0[i] = 1'b0;
            end
        end
        m_qdp[i] = qd;
        m_swp[i] = sw;
    endtask

    task automatic check_inst(input int i, input logic [31:0] w, input logic [31:0] bi,
                              input logic st0, input logic run);
        string p;
        p = (i == 0) ? "mb3" : "mb4";
        chk({p, ".w"}, w, (m_phase[i] != 0) ? (32'd1 << m_k[i]) : 32'd0);
        chk({p, ".running"}, {31'd0, run}, (m_phase[i] != 0) ? 32'd1 : 32'd0);
        chk({p, ".st0"}, {31'd0, st0}, {31'd0, m_st0[i]});
        if (m_phase[i] != 0) chk({p, ".beat_idx"}, bi, m_k[i]);
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge t3) begin
        if (chk_en) begin
            check_inst(0, {29'd0, if3.w}, {30'd0, if3.beat_idx}, if3.st0, if3.running);
            check_inst(1, {28'd0, if4.w}, {30'd0, if4.beat_idx}, if4.st0, if4.running);
`ifdef HW_CTRL_SEQ_INT_EN
            chk("mb3.int_ack", {31'd0, if3.int_ack}, {31'd0, m_ack[0]});
            chk("mb3.int_cyc", {31'd0, if3.int_cyc}, (m_phase[0] == 2) ? 32'd1 : 32'd0);
            chk("mb4.int_ack", {31'd0, if4.int_ack}, {31'd0, m_ack[1]});
            chk("mb4.int_cyc", {31'd0, if4.int_cyc}, (m_phase[1] == 2) ? 32'd1 : 32'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge t3);
        model_step(0);
        model_step(1);
        @(negedge t3);
    endtask

    task automatic exp_w(input string nm, input logic [2:0] e3, input logic [3:0] e4);
        chk({nm, ".w3"}, {29'd0, if3.w}, {29'd0, e3});
        chk({nm, ".w4"}, {28'd0, if4.w}, {28'd0, e4});
    endtask

    task automatic do_clr();
        clr = 1'b1; tick(); clr = 1'b0;
    endtask

    initial begin
        clr = 1'b1; qd = 1'b0; sw = 3'b000; short_i = 1'b0; long_i = 1'b0;
        stop_i = 1'b0; sst0_i = 1'b0;
`ifdef HW_CTRL_SEQ_INT_EN
        int_req = 1'b0;
`endif
        tick();
        chk_en = 1'b1;
        clr = 1'b0;
        // Reset state
        exp_w("rst", 3'b000, 4'b0000);
        chk("rst.running", {31'd0, if3.running}, 32'd0);
        chk("rst.beat_idx", {30'd0, if3.beat_idx}, 32'd0);
        chk("rst.st0", {31'd0, if3.st0}, 32'd0);

        // Two-beat instructions
        qd = 1'b1; tick(); qd = 1'b0;
        exp_w("two.b0", 3'b001, 4'b0001); chk("two.bi0", {30'd0, if3.beat_idx}, 32'd0);
        tick(); exp_w("two.b1", 3'b010, 4'b0010); chk("two.bi1", {30'd0, if3.beat_idx}, 32'd1);
        tick(); exp_w("two.b2", 3'b001, 4'b0001); chk("two.bi2", {30'd0, if3.beat_idx}, 32'd0);
        tick(); exp_w("two.b3", 3'b010, 4'b0010); chk("two.bi3", {30'd0, if3.beat_idx}, 32'd1);

        // Long instructions wrap at MAX_BEATS-1
        do_clr(); long_i = 1'b1;
        qd = 1'b1; tick(); qd = 1'b0;
        exp_w("long.b0", 3'b001, 4'b0001);
        tick(); exp_w("long.b1", 3'b010, 4'b0010);
        tick(); exp_w("long.b2", 3'b100, 4'b0100);
        tick(); exp_w("long.b3", 3'b001, 4'b1000);
        tick(); exp_w("long.b4", 3'b010, 4'b0001);

        // Stop at W2, resume at W3
        do_clr();
        qd = 1'b1; tick(); qd = 1'b0;
        tick(); exp_w("stop.w2", 3'b010, 4'b0010);
        stop_i = 1'b1; tick(); stop_i = 1'b0;
        exp_w("stop.halt", 3'b000, 4'b0000);
        chk("stop.running", {31'd0, if3.running}, 32'd0);
        qd = 1'b1; tick(); qd = 1'b0;
        exp_w("stop.resume", 3'b100, 4'b0100);
        long_i = 1'b0;

        // st0 set/clear and mode change
        sw = 3'b100; do_clr();
        qd = 1'b1; tick(); qd = 1'b0;
        sst0_i = 1'b1; tick(); sst0_i = 1'b0;
        chk("st0.set", {31'd0, if3.st0}, 32'd1);
        tick(); chk("st0.clr", {31'd0, if3.st0}, 32'd0);
        exp_w("st0.w1", 3'b001, 4'b0001);
        sst0_i = 1'b1; tick(); sst0_i = 1'b0;
        sw = 3'b010; tick();
        chk("mode.st0", {31'd0, if3.st0}, 32'd0);
        exp_w("mode.halt", 3'b000, 4'b0000);
        qd = 1'b1; tick(); qd = 1'b0;
        exp_w("mode.restart", 3'b001, 4'b0001);

`ifdef HW_CTRL_SEQ_INT_EN
        // Interrupt cycle, then clr in the middle of another one
        sw = 3'b000; do_clr();
        qd = 1'b1; tick(); qd = 1'b0;
        sst0_i = 1'b1; int_req = 1'b1; tick(); sst0_i = 1'b0;
        tick();
        chk("int.ack", {31'd0, if3.int_ack}, 32'd1);
        chk("int.cyc0", {31'd0, if3.int_cyc}, 32'd1);
        exp_w("int.w1", 3'b001, 4'b0001);
        tick();
        chk("int.ack1", {31'd0, if3.int_ack}, 32'd0);
        chk("int.cyc1", {31'd0, if3.int_cyc}, 32'd1);
        tick();
        chk("int.done", {31'd0, if3.int_cyc}, 32'd0);
        exp_w("int.run", 3'b001, 4'b0001);
        tick(); tick();
        chk("int2.cyc", {31'd0, if3.int_cyc}, 32'd1);
        do_clr();
        exp_w("int.clr", 3'b000, 4'b0000);
        chk("int.clr.cyc", {31'd0, if3.int_cyc}, 32'd0);
        int_req = 1'b0;
`endif

        // Randomized phase
        for (int n = 0; n < 3000; n++) begin
            clr     = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 9) < 3) qd = ~qd;
            if ($urandom_range(0, 99) == 0) sw = 3'($urandom_range(0, 7));
            else if ($urandom_range(0, 49) == 0) sw = 3'b100;
            short_i = ($urandom_range(0, 9) < 2);
            long_i  = ($urandom_range(0, 9) < 5);
            stop_i  = ($urandom_range(0, 99) < 4);
            sst0_i  = ($urandom_range(0, 99) < 8);
`ifdef HW_CTRL_SEQ_INT_EN
            int_req = ($urandom_range(0, 9) < 5);
`endif
            tick();
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
